mem_loader_fsm: RTL and testbench

MEM_LOADER_FSM -- requirements
Module: mem_loader_fsm

---
 rtl/mem_loader_fsm.sv | 168 ++++++++++++++++
 tb/tb_mem_loader_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader_fsm.sv
// +----------------------------------------------------------------------------+
// | mem_loader_fsm: unpacks host words into a byte memory and sums its bytes.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_loader_fsm #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_wr,
  input  logic [31:0]       ctrl_data,
  input  logic              data_wr,
  input  logic [31:0]       data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       ready,
  output logic [31:0]       answer
);

  localparam logic [1:0] c_OP_LOAD  = 2'd1;
  localparam logic [1:0] c_OP_SUM   = 2'd2;
  localparam logic [1:0] c_OP_CLEAR = 2'd3;
  localparam logic [8:0] c_DEPTH    = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_UNPACK = 3'd2,
    S_SUM    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [8:0]  r_rd_ptr, w_rd_ptr_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [1:0]  r_byte_idx, w_byte_idx_nxt;
  logic        r_full, w_full_nxt;
  logic        r_overflow, w_overflow_nxt;
  logic        r_done, w_done_nxt;
  logic [31:0] r_answer, w_answer_nxt;
  logic        r_rd_valid;
  logic [1:0]  w_op;
  logic        w_clear;
  logic        w_busy;
  logic        w_unused;

  assign w_op     = ctrl_data[1:0];
  assign w_unused = ^ctrl_data[31:2];
  // CLEAR is honoured in every state and overrides whatever else happens this cycle.
  assign w_clear  = ctrl_wr && (w_op == c_OP_CLEAR);
  assign w_busy   = (r_state == S_UNPACK) || (r_state == S_SUM) || (r_state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_answer   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_word     <= w_word_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_full     <= w_full_nxt;
      r_overflow <= w_overflow_nxt;
      r_done     <= w_done_nxt;
      r_answer   <= w_answer_nxt;
      r_rd_valid <= mem_re && !w_clear;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_word_nxt     = r_word;
    w_byte_idx_nxt = r_byte_idx;
    w_full_nxt     = r_full;
    w_overflow_nxt = r_overflow;
    w_done_nxt     = r_done;
    w_answer_nxt   = r_answer;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;

    // Read data returns one cycle after mem_re, so accumulation trails the read.
    if (r_rd_valid) w_answer_nxt = r_answer + {24'd0, mem_rdata};

    case (r_state)
      S_IDLE, S_LOAD: begin
        if (ctrl_wr) begin
          if (w_op == c_OP_LOAD) begin
            w_wr_ptr_nxt   = '0;
            w_full_nxt     = 1'b0;
            w_overflow_nxt = 1'b0;
            w_done_nxt     = 1'b0;
            w_state_nxt    = S_LOAD;
          end else if (w_op == c_OP_SUM) begin
            w_done_nxt   = 1'b0;
            w_answer_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_state_nxt  = (r_wr_ptr == 9'd0) ? S_DRAIN : S_SUM;
          end
        end else if ((r_state == S_LOAD) && data_wr) begin
          w_word_nxt     = data_in;
          w_byte_idx_nxt = 2'd0;
          w_state_nxt    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        mem_addr  = r_wr_ptr[ADDR_W-1:0];
        mem_wdata = r_word[{r_byte_idx, 3'b000} +: 8];
        if (r_wr_ptr != c_DEPTH) begin
          mem_we       = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + 9'd1;
        end
        if (w_wr_ptr_nxt == c_DEPTH) w_full_nxt = 1'b1;
        w_byte_idx_nxt = r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) w_state_nxt = S_LOAD;
        if (data_wr) w_overflow_nxt = 1'b1;
      end
      S_SUM: begin
        mem_re       = 1'b1;
        mem_addr     = r_rd_ptr[ADDR_W-1:0];
        w_rd_ptr_nxt = r_rd_ptr + 9'd1;
        if (r_rd_ptr == r_wr_ptr - 9'd1) w_state_nxt = S_DRAIN;
        if (data_wr) w_overflow_nxt = 1'b1;
      end
      S_DRAIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        if (data_wr) w_overflow_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_clear) begin
      w_state_nxt    = S_IDLE;
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_answer_nxt   = '0;
      w_full_nxt     = 1'b0;
      w_overflow_nxt = 1'b0;
      w_done_nxt     = 1'b0;
    end
  end

  assign ready  = {15'd0, r_wr_ptr, 4'd0, r_overflow, r_full, w_busy, r_done};
  assign answer = r_answer;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader_fsm.sv
// Directed self-checking bench for mem_loader_fsm with a byte memory model.
`default_nettype none

module tb_mem_loader_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_wr = 1'b0;
  logic [31:0] ctrl_data = '0;
  logic        data_wr = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [31:0] ready;
  logic [31:0] answer;

  int checks = 0;
  int errors = 0;
  int n_we = 0;
  int n_re = 0;
  logic both_seen = 1'b0;
  logic [7:0] mem [0:255];

  mem_loader_fsm #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
    .data_wr(data_wr), .data_in(data_in), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .ready(ready), .answer(answer)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      n_we <= n_we + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      n_re <= n_re + 1;
    end
    if (mem_we && mem_re) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input logic [1:0] op);
    ctrl_wr = 1'b1;
    ctrl_data = {30'd0, op};
    tick();
    ctrl_wr = 1'b0;
  endtask

  initial begin
    int snap_we, snap_re;
    tick();
    tick();
    check("rst_ready", ready, 32'h0);
    check("rst_answer", answer, 32'h0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_re", {31'd0, mem_re}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;

    // Single word load and sum
    ctrl(2'd1);
    data_wr = 1'b1;
    data_in = 32'h04030201;
    tick();
    data_wr = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("unp_we", {31'd0, mem_we}, 32'd1);
      check("unp_addr", {24'd0, mem_addr}, b);
      check("unp_wdata", {24'd0, mem_wdata}, b + 1);
      if (b == 0) check("unp_busy", {31'd0, ready[1]}, 32'd1);
      tick();
    end
    check("load1_ready", ready, 32'h0000_0400);
    snap_re = n_re;
    ctrl(2'd2);
    for (int k = 1; k <= 6; k++) begin
      check("sum1_done", {31'd0, ready[0]}, (k == 6) ? 32'd1 : 32'd0);
      if (k < 6) tick();
    end
    check("sum1_answer", answer, 32'd10);
    check("sum1_ready", ready, 32'h0000_0401);
    check("sum1_reads", n_re - snap_re, 32'd4);

    // Clear, then sum of an empty buffer
    ctrl(2'd3);
    check("clr_ready", ready, 32'h0);
    check("clr_answer", answer, 32'h0);
    snap_re = n_re;
    ctrl(2'd2);
    check("empty_done_e1", {31'd0, ready[0]}, 32'd0);
    tick();
    check("empty_done_e2", {31'd0, ready[0]}, 32'd1);
    check("empty_answer", answer, 32'd0);
    check("empty_reads", n_re - snap_re, 32'd0);

    // Second data_wr during unpack is dropped and flagged
    snap_we = n_we;
    ctrl(2'd1);
    data_wr = 1'b1;
    data_in = 32'h11223344;
    tick();
    data_wr = 1'b0;
    tick();
    data_wr = 1'b1;
    data_in = 32'h55667788;
    tick();
    data_wr = 1'b0;
    tick();
    tick();
    check("ovf_ready", ready, 32'h0000_0408);
    check("ovf_writes", n_we - snap_we, 32'd4);

    // Fill to capacity; the 65th word must not write
    snap_we = n_we;
    ctrl(2'd1);
    for (int w = 0; w < 65; w++) begin
      data_wr = 1'b1;
      data_in = 32'hFFFF_FFFF;
      tick();
      data_wr = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (w == 64) check("full_no_we", {31'd0, mem_we}, 32'd0);
        tick();
      end
    end
    check("full_writes", n_we - snap_we, 32'd256);
    check("full_ready", ready, 32'h0001_0004);
    ctrl(2'd2);
    for (int k = 1; k < 257; k++) tick();
    check("full_done_early", {31'd0, ready[0]}, 32'd0);
    tick();
    check("full_done", {31'd0, ready[0]}, 32'd1);
    check("full_answer", answer, 32'd65280);
    check("full_sum_ready", ready, 32'h0001_0005);

    // CLEAR aborts a running SUM
    ctrl(2'd2);
    tick();
    tick();
    check("mid_sum_re", {31'd0, mem_re}, 32'd1);
    ctrl(2'd3);
    check("abort_re", {31'd0, mem_re}, 32'd0);
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_ready", ready, 32'h0);
    check("abort_answer", answer, 32'h0);
    tick();
    check("abort_answer_hold", answer, 32'h0);
    check("abort_re_hold", {31'd0, mem_re}, 32'd0);

    // Reset mid-UNPACK, with a competing LOAD command
    ctrl(2'd1);
    data_wr = 1'b1;
    data_in = 32'hA5A5A5A5;
    tick();
    data_wr = 1'b0;
    tick();
    check("mid_unp_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    ctrl_wr = 1'b1;
    ctrl_data = 32'd1;
    tick();
    reset = 1'b0;
    ctrl_wr = 1'b0;
    snap_we = n_we;
    check("rstab_we", {31'd0, mem_we}, 32'd0);
    check("rstab_re", {31'd0, mem_re}, 32'd0);
    check("rstab_addr", {24'd0, mem_addr}, 32'd0);
    check("rstab_ready", ready, 32'h0);
    check("rstab_answer", answer, 32'h0);
    data_wr = 1'b1;
    tick();
    data_wr = 1'b0;
    tick();
    check("idle_data_ignored", ready, 32'h0);
    check("idle_no_writes", n_we - snap_we, 32'd0);
    check("never_we_and_re", {31'd0, both_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
